branch_redirect_ctrl: RTL and testbench

- Front-end branch controller. Predicts fetch direction and target from a direct-mapped BTB holding 2-bit saturating counters.
- Checks the EX-stage branch-unit outcome against the prediction carried down the pipe.
- On mismatch, sequences a registered redirect/flush handshake to fetch while holding EX.

---
 rtl/branch_redirect_ctrl.sv | 130 +++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_ctrl
// Brief    : BTB-based fetch predictor with EX-stage mispredict redirect/flush.
// Revision : 1.0
// ============================================================================
module branch_redirect_ctrl #(
   parameter int BTB_ENTRIES = 16,
   parameter int IDX_W       = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic        ex_is_branch,
   input  logic        ex_is_jump,
   input  logic        ex_branch_taken,
   input  logic [31:0] ex_branch_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        ex_hold,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic [31:0] mispredict_cnt
);

   localparam int TAG_W = 32 - IDX_W - 2;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_REDIRECT = 1'b1} state_t;

   state_t                   r_state;
   logic [BTB_ENTRIES-1:0]   r_valid;
   logic [TAG_W-1:0]         r_tag    [BTB_ENTRIES];
   logic [31:0]              r_target [BTB_ENTRIES];
   logic [1:0]               r_ctr    [BTB_ENTRIES];
   logic [31:0]              r_redirect_pc;
   logic [31:0]              r_mispredict_cnt;

   logic [IDX_W-1:0] w_if_idx, w_ex_idx;
   logic [TAG_W-1:0] w_if_tag, w_ex_tag;
   logic             w_if_hit, w_ex_hit;
   logic             w_resolve, w_is_cf, w_actual_taken, w_mispredict;
   logic [31:0]      w_correct_pc;
   logic             w_unused;

   assign w_unused = &{1'b0, if_pc[1:0]};

   // Fetch lookup reads the array before any same-cycle write lands.
   assign w_if_idx    = if_pc[IDX_W+1:2];
   assign w_if_tag    = if_pc[31:IDX_W+2];
   assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
   assign pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
   assign pred_target = pred_taken ? r_target[w_if_idx] : 32'd0;

   assign w_ex_idx       = ex_pc[IDX_W+1:2];
   assign w_ex_tag       = ex_pc[31:IDX_W+2];
   assign w_ex_hit       = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
   assign w_resolve      = (r_state == S_IDLE) && ex_valid;
   assign w_is_cf        = ex_is_branch | ex_is_jump;
   assign w_actual_taken = ex_is_jump | (ex_is_branch & ex_branch_taken);
   assign w_mispredict   = (w_actual_taken != ex_pred_taken) |
                           (w_actual_taken & ex_pred_taken & (ex_branch_target != ex_pred_target));
   assign w_correct_pc   = w_actual_taken ? ex_branch_target : ex_pc + 32'd4;

   // All handshake outputs come straight from the state flop: no path from redirect_ready.
   assign redirect_valid = (r_state == S_REDIRECT);
   assign ex_hold        = (r_state == S_REDIRECT);
   assign flush_if_id    = (r_state == S_REDIRECT);
   assign flush_id_ex    = (r_state == S_REDIRECT);
   assign redirect_pc    = r_redirect_pc;
   assign mispredict_cnt = r_mispredict_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state          <= S_IDLE;
         r_valid          <= '0;
         r_redirect_pc    <= 32'd0;
         r_mispredict_cnt <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_resolve) begin
                  if (w_is_cf) begin
                     if (!w_ex_hit && w_actual_taken)
                        r_valid[w_ex_idx] <= 1'b1;
                  end else if (ex_pred_taken && w_ex_hit) begin
                     r_valid[w_ex_idx] <= 1'b0;
                  end
                  if (w_mispredict) begin
                     r_redirect_pc    <= w_correct_pc;
                     r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
                     r_state          <= S_REDIRECT;
                  end
               end
            end
            S_REDIRECT: begin
               if (redirect_ready)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Payload arrays need no reset; validity alone gates their use.
   always_ff @(posedge clk) begin
      if (rst_n && w_resolve && w_is_cf) begin
         if (w_ex_hit) begin
            if (w_actual_taken) begin
               r_ctr[w_ex_idx]    <= (r_ctr[w_ex_idx] == 2'b11) ? 2'b11 : r_ctr[w_ex_idx] + 2'd1;
               r_target[w_ex_idx] <= ex_branch_target;
            end else begin
               r_ctr[w_ex_idx]    <= (r_ctr[w_ex_idx] == 2'b00) ? 2'b00 : r_ctr[w_ex_idx] - 2'd1;
            end
         end else if (w_actual_taken) begin
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= ex_branch_target;
            r_ctr[w_ex_idx]    <= ex_is_jump ? 2'b11 : 2'b10;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_redirect_ctrl
// Brief    : Directed self-checking bench for branch_redirect_ctrl.
// Revision : 1.0
// ============================================================================
module tb_branch_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_is_branch;
   logic        ex_is_jump;
   logic        ex_branch_taken;
   logic [31:0] ex_branch_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        ex_hold;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic [31:0] mispredict_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   branch_redirect_ctrl #(.BTB_ENTRIES(16), .IDX_W(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .if_pc            (if_pc),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .ex_valid         (ex_valid),
      .ex_pc            (ex_pc),
      .ex_is_branch     (ex_is_branch),
      .ex_is_jump       (ex_is_jump),
      .ex_branch_taken  (ex_branch_taken),
      .ex_branch_target (ex_branch_target),
      .ex_pred_taken    (ex_pred_taken),
      .ex_pred_target   (ex_pred_target),
      .ex_hold          (ex_hold),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .redirect_ready   (redirect_ready),
      .flush_if_id      (flush_if_id),
      .flush_id_ex      (flush_id_ex),
      .mispredict_cnt   (mispredict_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic ex_drive(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                           input logic tk, input logic [31:0] tgt, input logic ptk,
                           input logic [31:0] ptgt);
      ex_valid         = v;
      ex_pc            = pc;
      ex_is_branch     = br;
      ex_is_jump       = jmp;
      ex_branch_taken  = tk;
      ex_branch_target = tgt;
      ex_pred_taken    = ptk;
      ex_pred_target   = ptgt;
   endtask

   task automatic chk_redirect(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
      chk({tag, "_rv"},   {31'd0, redirect_valid}, 32'd1);
      chk({tag, "_hold"}, {31'd0, ex_hold},        32'd1);
      chk({tag, "_fl"},   {30'd0, flush_if_id, flush_id_ex}, 32'd3);
      chk({tag, "_pc"},   redirect_pc,             pc);
      chk({tag, "_cnt"},  mispredict_cnt,          cnt);
   endtask

   task automatic chk_idle(input string tag, input logic [31:0] cnt);
      chk({tag, "_rv"},   {31'd0, redirect_valid}, 32'd0);
      chk({tag, "_hold"}, {31'd0, ex_hold},        32'd0);
      chk({tag, "_fl"},   {30'd0, flush_if_id, flush_id_ex}, 32'd0);
      chk({tag, "_cnt"},  mispredict_cnt,          cnt);
   endtask

   task automatic chk_pred(input string tag, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt);
      if_pc = pc;
      #1;
      chk({tag, "_ptk"}, {31'd0, pred_taken}, {31'd0, tk});
      chk({tag, "_ptg"}, pred_target,         tgt);
   endtask

   initial begin
      rst_n          = 1'b0;
      if_pc          = 32'h100;
      redirect_ready = 1'b1;
      ex_drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;

      // 1: reset state
      chk("rst_pc", redirect_pc, 32'h0);
      chk_idle("rst", 32'd0);
      chk_pred("rst", 32'h100, 1'b0, 32'h0);

      // 2: taken branch predicted not-taken, allocates with ctr=10
      ex_drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
      tick();
      ex_valid = 1'b0;
      chk_redirect("br_alloc", 32'h80, 32'd1);
      chk_pred("br_alloc", 32'h100, 1'b1, 32'h80);
      chk_pred("tag_miss", 32'h140, 1'b0, 32'h0);
      tick();
      chk_idle("br_alloc_done", 32'd1);

      // 3: not-taken mispredict -> ctr 01, then 00, then taken -> 01 (saturated low)
      ex_drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
      tick();
      ex_valid = 1'b0;
      chk_redirect("br_nt", 32'h104, 32'd2);
      chk_pred("br_nt", 32'h100, 1'b0, 32'h0);
      tick();
      ex_drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
      tick();
      ex_valid = 1'b0;
      chk_idle("br_nt_ok", 32'd2);
      ex_drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h88, 1'b0, 32'h0);
      tick();
      ex_valid = 1'b0;
      chk_redirect("br_sat", 32'h88, 32'd3);
      chk_pred("br_sat", 32'h100, 1'b0, 32'h0);
      tick();

      // 4: jump allocation, then target mismatch retargets, then a correct prediction
      ex_drive(1'b1, 32'h208, 1'b0, 1'b1, 1'b0, 32'h300, 1'b0, 32'h0);
      tick();
      ex_valid = 1'b0;
      chk_redirect("jmp_alloc", 32'h300, 32'd4);
      chk_pred("jmp_alloc", 32'h208, 1'b1, 32'h300);
      tick();
      ex_drive(1'b1, 32'h208, 1'b0, 1'b1, 1'b0, 32'h304, 1'b1, 32'h300);
      tick();
      ex_valid = 1'b0;
      chk_redirect("jmp_tgt", 32'h304, 32'd5);
      chk_pred("jmp_tgt", 32'h208, 1'b1, 32'h304);
      tick();
      ex_drive(1'b1, 32'h208, 1'b0, 1'b1, 1'b0, 32'h304, 1'b1, 32'h304);
      tick();
      ex_valid = 1'b0;
      chk_idle("jmp_ok", 32'd5);

      // Aliasing non-branch at top of address space: fall-through wraps to 0
      ex_drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h50);
      tick();
      ex_valid = 1'b0;
      chk_redirect("alias_wrap", 32'h0, 32'd6);
      tick();
      // Aliasing non-branch with matching tag invalidates the entry
      ex_drive(1'b1, 32'h208, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h304);
      tick();
      ex_valid = 1'b0;
      chk_redirect("alias_inv", 32'h20C, 32'd7);
      chk_pred("alias_inv", 32'h208, 1'b0, 32'h0);
      tick();

      // 5: backpressured redirect ignores EX inputs while held
      redirect_ready = 1'b0;
      ex_drive(1'b1, 32'h414, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
      tick();
      ex_drive(1'b1, 32'h61C, 1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0);
      chk_redirect("bp_c1", 32'h500, 32'd8);
      tick();
      chk_redirect("bp_c2", 32'h500, 32'd8);
      tick();
      chk_redirect("bp_c3", 32'h500, 32'd8);
      redirect_ready = 1'b1;
      ex_valid       = 1'b0;
      tick();
      chk_idle("bp_done", 32'd8);
      chk_pred("bp_ignored", 32'h61C, 1'b0, 32'h0);
      chk_pred("bp_trained", 32'h414, 1'b1, 32'h500);

      // 6: reset during REDIRECT drops it and clears the BTB
      redirect_ready = 1'b0;
      ex_drive(1'b1, 32'h830, 1'b1, 1'b0, 1'b1, 32'h900, 1'b0, 32'h0);
      tick();
      ex_valid = 1'b0;
      chk_redirect("pre_rst", 32'h900, 32'd9);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_pc", redirect_pc, 32'h0);
      chk_idle("mid_rst", 32'd0);
      chk_pred("mid_rst", 32'h414, 1'b0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
